uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path among NUM_REQ byte-stream requesters.
- Grants the transmitter round-robin and holds the grant for a packet (until the last byte, MAX_BURST bytes, or requester withdrawal).
- Sequences each byte through the transmitter's ready/done handshake, with a watchdog that recovers from a stalled transmitter.
- Sits in the system clock domain between client logic and the UART TX path; i_Tx_Done / i_Tx_Active are delivered in the clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).
- TX_TIMEOUT, 200000, clk cycles allowed in WAIT_DONE before abort; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- i_Req  input  NUM_REQ  per-requester byte-valid/request.
- i_Byte  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- i_Last  input  NUM_REQ  per-requester flag: the presented byte ends the packet.
- o_Ack  output  NUM_REQ  one-cycle pulse: the presented byte was taken; requester presents its next byte or drops i_Req.
- o_Grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- o_Tx_Ready  output  1  one-cycle start strobe to the transmitter.
- o_Tx_Byte  output  8  byte to transmit; held stable from the strobe until done or abort.
- i_Tx_Done  input  1  one-cycle pulse: the transmitter finished a byte.
- i_Tx_Active  input  1  transmitter is busy.
- o_Busy  output  1  high whenever the state is not IDLE.
- o_Timeout  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (asynchronous, immediate, legal at any time, including mid-byte):
  - o_Ack, o_Grant, o_Tx_Ready, o_Busy, o_Timeout = 0; o_Tx_Byte = 8'h00.
  - State = IDLE, round-robin pointer = 0, burst count = 0, watchdog count = 0.
- State machine: IDLE, SEND, WAIT_DONE.
- IDLE:
  - Arbitration happens only when i_Tx_Active = 0 and |i_Req = 1.
  - The winner is the first asserted i_Req scanning upward from the pointer index, wrapping at NUM_REQ-1 to 0.
  - On a win: register o_Grant and o_Tx_Byte, clear burst count, go to SEND.
  - Arbitration is a registered decision; IDLE to SEND takes 1 cycle.
- SEND (exactly 1 cycle):
  - o_Tx_Ready = 1 and o_Ack[owner] = 1; burst count += 1; latch the owner's i_Last; go to WAIT_DONE.
  - i_Tx_Done in this cycle is ignored.
- WAIT_DONE:
  - o_Tx_Byte is held; the watchdog counts cycles spent here.
  - On i_Tx_Done, continue if all of the following hold: i_Req[owner] = 1, latched last = 0, burst count < MAX_BURST.
    - Continue: load the owner's current i_Byte into o_Tx_Byte, clear the watchdog, go to SEND (1 cycle after done).
    - Otherwise release: o_Grant = 0, pointer = (owner+1) mod NUM_REQ, go to IDLE.
  - If TX_TIMEOUT != 0 and the watchdog reaches TX_TIMEOUT without a done:
    - o_Timeout pulses for 1 cycle, followed by a release identical to the normal release.
  - A done arriving on the same cycle the watchdog expires counts as a done; no timeout is reported.
- Latency: with the transmitter idle, i_Req rises in cycle n, o_Tx_Ready and o_Ack occur in n+1, and WAIT_DONE begins in n+2. Back-to-back bytes: done in cycle m gives the next o_Tx_Ready in m+1.
- Requests from non-owners never affect the current grant. Requests may change at any time; only the value sampled at the arbitration cycle matters.
- Pointer wrap: owner NUM_REQ-1 gives pointer 0.
- Burst count width is clog2(MAX_BURST+1) and is compared unsigned. MAX_BURST = 1 forces release after every byte.
- o_Grant is always one-hot or zero. o_Ack is always a subset of o_Grant. o_Ack and o_Tx_Ready are always coincident.

Test Plan:
- Single requester: i_Req=4'b0001, i_Byte[7:0]=8'hA5, i_Last=1.
  - Expect o_Tx_Ready and o_Ack[0] 1 cycle after the request, o_Tx_Byte=A5.
  - After the done pulse: o_Grant=0, pointer=1, o_Busy=0.
- Round-robin fairness: all four requesters request continuously, each byte with last=1.
  - Expect grant order 0,1,2,3,0 over five packets, one byte each.
- Burst limit: MAX_BURST=3, requester 2 holds i_Req with last=0, requester 3 also requesting.
  - Expect exactly 3 strobes for requester 2, then release and grant to 3.
- Withdrawal: requester 1 drops i_Req during WAIT_DONE of its 2nd byte.
  - Expect release on that done with no further strobe, and pointer=2.
- Watchdog: TX_TIMEOUT=10, i_Tx_Done never pulses.
  - Expect o_Timeout high in the 10th WAIT_DONE cycle, then release and re-arbitration.
  - Edge case: a done on exactly the 10th cycle gives no o_Timeout.
- Reset mid-packet: assert reset_n=0 during WAIT_DONE.
  - Expect all outputs 0 immediately and the pointer back at 0.
  - After deassertion with all requesters asserting: first grant to requester 0.
  - Additionally, i_Tx_Active=1 in IDLE blocks arbitration until it falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmit path among NUM_REQ byte-stream requesters.
// Ownership is granted round-robin and kept for a whole packet.
// A packet ends on the last byte, after MAX_BURST bytes, or when the owner
// withdraws its request.
// Each byte goes through a start-strobe / done handshake with the transmitter.
// A watchdog releases the grant if the transmitter never reports done.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   MAX_BURST   bytes per grant before forced release (1..255)
//   TX_TIMEOUT  cycles allowed waiting for done; 0 disables the watchdog
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   i_Req        per-requester byte-valid / request
//   i_Byte       per-requester byte, requester k on bits [8k+7:8k]
//   i_Last       per-requester "presented byte ends the packet"
//   o_Ack        one-cycle pulse, the presented byte was taken
//   o_Grant      one-hot current owner, zero when idle
//   o_Tx_Ready   one-cycle start strobe to the transmitter
//   o_Tx_Byte    byte to transmit, stable from strobe until done/abort
//   i_Tx_Done    one-cycle pulse, transmitter finished a byte
//   i_Tx_Active  transmitter busy; blocks arbitration while high
//   o_Busy       high whenever not idle
//   o_Timeout    one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 16,
   parameter int TX_TIMEOUT = 200000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   i_Req,
   input  logic [8*NUM_REQ-1:0] i_Byte,
   input  logic [NUM_REQ-1:0]   i_Last,
   output logic [NUM_REQ-1:0]   o_Ack,
   output logic [NUM_REQ-1:0]   o_Grant,
   output logic                 o_Tx_Ready,
   output logic [7:0]           o_Tx_Byte,
   input  logic                 i_Tx_Done,
   input  logic                 i_Tx_Active,
   output logic                 o_Busy,
   output logic                 o_Timeout
);

   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam int WD_W    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT + 1) : 1;

   localparam logic [PTR_W:0]     NUM_REQ_W   = (PTR_W + 1)'(NUM_REQ);
   localparam logic [PTR_W-1:0]   LAST_IDX    = PTR_W'(NUM_REQ - 1);
   localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
   localparam logic [WD_W-1:0]    WD_LAST     = WD_W'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);
   localparam logic [NUM_REQ-1:0] GRANT_LSB   = NUM_REQ'(1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SEND      = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;

   logic [1:0]         state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [PTR_W-1:0]   owner_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [BURST_W-1:0] burst_q;
   logic               last_q;
   logic [WD_W-1:0]    wd_q;
   logic [7:0]         tx_byte_q;

   logic [7:0]         req_byte [NUM_REQ];
   logic [PTR_W:0]     cand;
   logic [PTR_W-1:0]   win_idx;
   logic               win_found;
   logic               keep_going;
   logic               wd_expire;
   logic               do_release;

   // Unpack the flat byte bus so requesters can be indexed directly.
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         req_byte[k] = i_Byte[8*k +: 8];
      end
   end

   // Round-robin pick: scan from the farthest candidate back toward the
   // pointer so the last hit, which is the nearest one, wins.
   // NOTE: every variable written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end
         if (i_Req[cand[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PTR_W-1:0];
         end
      end
   end

   // The owner keeps the transmitter only while it still requests, the last
   // byte has not gone out, and the burst allowance is not used up.
   always_comb begin
      keep_going = i_Req[owner_q] && !last_q && (burst_q < BURST_LIMIT);
      // A done in the expiry cycle wins over the watchdog.
      wd_expire  = (TX_TIMEOUT != 0) && (state_q == ST_WAIT_DONE) &&
                   (wd_q == WD_LAST) && !i_Tx_Done;
      do_release = (state_q == ST_WAIT_DONE) &&
                   ((i_Tx_Done && !keep_going) || wd_expire);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register in this block sees the values from before the clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         burst_q   <= '0;
         last_q    <= 1'b0;
         wd_q      <= '0;
         tx_byte_q <= 8'h00;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!i_Tx_Active && win_found) begin
                  grant_q   <= GRANT_LSB << win_idx;
                  owner_q   <= win_idx;
                  tx_byte_q <= req_byte[win_idx];
                  burst_q   <= '0;
                  state_q   <= ST_SEND;
               end
            end
            ST_SEND: begin
               // Any done seen during the strobe cycle is ignored.
               burst_q <= burst_q + 1'b1;
               last_q  <= i_Last[owner_q];
               wd_q    <= '0;
               state_q <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (do_release) begin
                  grant_q <= '0;
                  ptr_q   <= (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                  state_q <= ST_IDLE;
               end else if (i_Tx_Done) begin
                  tx_byte_q <= req_byte[owner_q];
                  wd_q      <= '0;
                  state_q   <= ST_SEND;
               end else if (TX_TIMEOUT != 0) begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   // Strobe and acknowledge are the same event, decoded from the SEND state.
   assign o_Tx_Ready = (state_q == ST_SEND);
   assign o_Ack      = grant_q & {NUM_REQ{state_q == ST_SEND}};
   assign o_Grant    = grant_q;
   assign o_Tx_Byte  = tx_byte_q;
   assign o_Busy     = (state_q != ST_IDLE);
   assign o_Timeout  = wd_expire;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (4 requesters, burst limit 3,
// watchdog 10).
// Expected strobes are queued as stimulus is driven.
// A negedge monitor pops the queue on every o_Tx_Ready and checks the
// output invariants.
// Single-byte arbitration cases run from a table.
// Bursts, withdrawal, watchdog, Tx_Active blocking and mid-packet reset are
// written out as explicit sequences.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   i_Req;
   logic [8*N-1:0] i_Byte;
   logic [N-1:0]   i_Last;
   logic [N-1:0]   o_Ack;
   logic [N-1:0]   o_Grant;
   logic           o_Tx_Ready;
   logic [7:0]     o_Tx_Byte;
   logic           i_Tx_Done;
   logic           i_Tx_Active;
   logic           o_Busy;
   logic           o_Timeout;

   typedef struct {
      logic [N-1:0] grant;
      logic [7:0]   data;
   } exp_t;

   typedef struct {
      logic [N-1:0]   req;
      logic [8*N-1:0] bytes;
      logic [N-1:0]   exp_grant;
      logic [7:0]     exp_byte;
   } vec_t;

   vec_t vecs [12];
   exp_t sb_q [$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   strobe_cnt [N];
   int   c2_before;

   uart_tx_arbiter #(
      .NUM_REQ    (N),
      .MAX_BURST  (3),
      .TX_TIMEOUT (10)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_Req       (i_Req),
      .i_Byte      (i_Byte),
      .i_Last      (i_Last),
      .o_Ack       (o_Ack),
      .o_Grant     (o_Grant),
      .o_Tx_Ready  (o_Tx_Ready),
      .o_Tx_Byte   (o_Tx_Byte),
      .i_Tx_Done   (i_Tx_Done),
      .i_Tx_Active (i_Tx_Active),
      .o_Busy      (o_Busy),
      .o_Timeout   (o_Timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Start of a cycle: just after the active edge, done defaults low.
   task automatic tick();
      @(posedge clk);
      #1;
      i_Tx_Done = 1'b0;
   endtask

   // Sampling point in the middle of the cycle.
   task automatic mid();
      @(negedge clk);
   endtask

   task automatic expect_strobe(input logic [N-1:0] g, input logic [7:0] d);
      exp_t e;
      e.grant = g;
      e.data  = d;
      sb_q.push_back(e);
   endtask

   // Scoreboard and invariants.
   always @(negedge clk) begin
      check("inv_onehot", 32'($onehot0(o_Grant)), 32'd1);
      check("inv_ack", {30'd0, o_Tx_Ready, |(o_Ack & ~o_Grant)}, {30'd0, |o_Ack, 1'b0});
      if (o_Tx_Ready) begin
         for (int k = 0; k < N; k++) begin
            if (o_Grant[k]) strobe_cnt[k]++;
         end
         if (sb_q.size() == 0) begin
            check("unexpected_strobe", 32'(sb_q.size()), 32'd1);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_grant", 32'(o_Grant), 32'(mon_e.grant));
            check("sb_ack", 32'(o_Ack), 32'(mon_e.grant));
            check("sb_byte", 32'(o_Tx_Byte), 32'(mon_e.data));
         end
      end
   end

   // One single-byte packet from idle: strobe one cycle after the request,
   // byte held while waiting, release on done.
   task automatic run_vec(input int idx);
      tick();
      i_Req  = vecs[idx].req;
      i_Byte = vecs[idx].bytes;
      i_Last = '1;
      expect_strobe(vecs[idx].exp_grant, vecs[idx].exp_byte);
      mid();
      check($sformatf("v%0d_idle", idx), 32'(o_Busy), 32'd0);
      tick();
      mid();
      check($sformatf("v%0d_strobe", idx), {27'd0, o_Tx_Ready, o_Ack}, {27'd1, vecs[idx].exp_grant});
      tick();
      i_Req = '0;
      mid();
      check($sformatf("v%0d_wait", idx), {22'd0, o_Busy, o_Tx_Ready, o_Tx_Byte}, {22'd0, 2'b10, vecs[idx].exp_byte});
      tick();
      i_Tx_Done = 1'b1;
      mid();
      tick();
      mid();
      check($sformatf("v%0d_release", idx), {27'd0, o_Busy, o_Grant}, 32'd0);
   endtask

   initial begin
      reset_n     = 1'b0;
      i_Req       = '0;
      i_Byte      = '0;
      i_Last      = '0;
      i_Tx_Done   = 1'b0;
      i_Tx_Active = 1'b0;
      for (int k = 0; k < N; k++) strobe_cnt[k] = 0;

      // Pointer starts at 0 and moves to winner+1 after each packet.
      vecs[0]  = '{4'b1111, 32'h03020100, 4'b0001, 8'h00};
      vecs[1]  = '{4'b1111, 32'h13121110, 4'b0010, 8'h11};
      vecs[2]  = '{4'b1111, 32'h23222120, 4'b0100, 8'h22};
      vecs[3]  = '{4'b1111, 32'h33323130, 4'b1000, 8'h33};
      vecs[4]  = '{4'b1111, 32'h43424140, 4'b0001, 8'h40};
      vecs[5]  = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5};
      vecs[6]  = '{4'b1000, 32'h5A000000, 4'b1000, 8'h5A};
      vecs[7]  = '{4'b0110, 32'h8B8A8988, 4'b0010, 8'h89};
      vecs[8]  = '{4'b0011, 32'h9B9A9998, 4'b0001, 8'h98};
      vecs[9]  = '{4'b1010, 32'hABAAA9A8, 4'b0010, 8'hA9};
      vecs[10] = '{4'b0101, 32'hBBBAB9B8, 4'b0100, 8'hBA};
      vecs[11] = '{4'b0101, 32'hCBCAC9C8, 4'b0001, 8'hC8};

      #2;
      check("rst_outputs", {13'd0, o_Ack, o_Grant, o_Tx_Ready, o_Tx_Byte, o_Busy, o_Timeout}, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;

      for (int v = 0; v < 12; v++) run_vec(v);

      // Burst limit: requester 2 streams without last, 3 waits its turn.
      c2_before = strobe_cnt[2];
      tick(); i_Req = 4'b1100; i_Last = '0; i_Byte = 32'hD0C0_0000;
      expect_strobe(4'b0100, 8'hC0); mid();
      tick(); mid(); check("burst_s1", 32'(o_Tx_Ready), 32'd1);
      tick(); i_Byte = 32'hD0C1_0000; mid();
      tick(); i_Tx_Done = 1'b1; expect_strobe(4'b0100, 8'hC1); mid();
      tick(); mid(); check("burst_s2", 32'(o_Tx_Ready), 32'd1);
      tick(); i_Byte = 32'hD0C2_0000; mid();
      tick(); i_Tx_Done = 1'b1; expect_strobe(4'b0100, 8'hC2); mid();
      tick(); mid(); check("burst_s3", 32'(o_Tx_Ready), 32'd1);
      tick(); mid(); check("burst_wait", 32'(o_Busy), 32'd1);
      tick(); i_Tx_Done = 1'b1; expect_strobe(4'b1000, 8'hD0); mid();
      tick(); mid(); check("burst_release", {27'd0, o_Busy, o_Grant}, 32'd0);
      tick(); mid(); check("burst_next_owner", 32'(o_Ack), 32'b1000);
      check("burst_count", 32'(strobe_cnt[2] - c2_before), 32'd3);
      tick(); i_Req = '0; mid();
      tick(); i_Tx_Done = 1'b1; mid();
      tick(); mid(); check("burst_idle", 32'(o_Busy), 32'd0);

      // Withdrawal: requester 1 drops its request while its 2nd byte is out.
      tick(); i_Req = 4'b0010; i_Byte = 32'h0000_E000;
      expect_strobe(4'b0010, 8'hE0); mid();
      tick(); mid(); check("wdraw_s1", 32'(o_Tx_Ready), 32'd1);
      tick(); i_Byte = 32'h0000_E100; mid();
      tick(); i_Tx_Done = 1'b1; expect_strobe(4'b0010, 8'hE1); mid();
      tick(); mid(); check("wdraw_s2", 32'(o_Ack), 32'b0010);
      tick(); i_Req = '0; mid();
      tick(); i_Tx_Done = 1'b1; mid();
      tick(); mid(); check("wdraw_release", {27'd0, o_Busy, o_Grant}, 32'd0);
      tick(); mid(); check("wdraw_no_strobe", 32'(o_Tx_Ready), 32'd0);
      tick(); i_Req = 4'b1111; i_Last = '1; i_Byte = 32'h4433_2211;
      expect_strobe(4'b0100, 8'h33); mid();
      tick(); mid(); check("wdraw_ptr", 32'(o_Grant), 32'b0100);
      tick(); i_Req = '0; mid();
      tick(); i_Tx_Done = 1'b1; mid();
      tick(); mid(); check("wdraw_idle", 32'(o_Busy), 32'd0);

      // Watchdog: no done at all, abort in the 10th waiting cycle.
      tick(); i_Req = 4'b0001; i_Byte = 32'h0000_00F0;
      expect_strobe(4'b0001, 8'hF0); mid();
      tick(); i_Req = '0; mid(); check("wdog_strobe", 32'(o_Tx_Ready), 32'd1);
      for (int k = 1; k <= 10; k++) begin
         tick(); mid();
         if (k < 10) check($sformatf("wdog_quiet%0d", k), {30'd0, o_Timeout, o_Busy}, 32'b01);
         else        check("wdog_fire", {30'd0, o_Timeout, o_Busy}, 32'b11);
      end
      tick(); i_Req = 4'b0011; i_Byte = 32'h0000_1F0E;
      expect_strobe(4'b0010, 8'h1F); mid();
      check("wdog_release", {26'd0, o_Timeout, o_Busy, o_Grant}, 32'd0);
      tick(); i_Req = '0; mid(); check("wdog_rearb", 32'(o_Ack), 32'b0010);
      // Done exactly in the 10th waiting cycle beats the watchdog.
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 10) i_Tx_Done = 1'b1;
         mid();
         check($sformatf("wdog_edge%0d", k), {30'd0, o_Timeout, o_Busy}, 32'b01);
      end
      tick(); mid(); check("wdog_edge_release", {26'd0, o_Timeout, o_Busy, o_Grant}, 32'd0);

      // Transmitter busy in IDLE blocks arbitration until it falls.
      tick(); i_Tx_Active = 1'b1; i_Req = 4'b0001; i_Byte = 32'h0000_0077; mid();
      check("active_hold0", {30'd0, o_Busy, o_Tx_Ready}, 32'd0);
      tick(); mid(); check("active_hold1", {30'd0, o_Busy, o_Tx_Ready}, 32'd0);
      tick(); mid(); check("active_hold2", {30'd0, o_Busy, o_Tx_Ready}, 32'd0);
      tick(); i_Tx_Active = 1'b0; expect_strobe(4'b0001, 8'h77); mid();
      check("active_release", 32'(o_Busy), 32'd0);
      tick(); i_Req = '0; mid(); check("active_strobe", 32'(o_Ack), 32'b0001);
      tick(); i_Tx_Done = 1'b1; mid();
      tick(); mid(); check("active_idle", 32'(o_Busy), 32'd0);

      // Reset in the middle of a packet.
      tick(); i_Req = 4'b0100; i_Last = '0; i_Byte = 32'h0099_0000;
      expect_strobe(4'b0100, 8'h99); mid();
      tick(); mid(); check("rstm_strobe", 32'(o_Tx_Ready), 32'd1);
      tick(); mid(); check("rstm_wait", {23'd0, o_Busy, o_Tx_Byte}, {23'd1, 8'h99});
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("rstm_outputs", {13'd0, o_Ack, o_Grant, o_Tx_Ready, o_Tx_Byte, o_Busy, o_Timeout}, 32'd0);
      i_Req = 4'b1111; i_Last = '1; i_Byte = 32'h5544_3322;
      tick(); mid(); check("rstm_hold", 32'(o_Busy), 32'd0);
      tick(); reset_n = 1'b1; expect_strobe(4'b0001, 8'h22); mid();
      check("rstm_idle", 32'(o_Busy), 32'd0);
      tick(); i_Req = '0; mid(); check("rstm_first_grant", 32'(o_Grant), 32'b0001);
      tick(); i_Tx_Done = 1'b1; mid();
      tick(); mid(); check("rstm_final_idle", {27'd0, o_Busy, o_Grant}, 32'd0);

      tick(); mid();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
